// File: rtl/mixcol_engine_pkg.sv
// Shared GF(2^8) helpers, FSM state type and column slicing for the MixColumns engine.
package aes_mix_pkg;

    localparam logic [7:0] GF_RED = 8'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_RED : 8'h00);
    endfunction

    // Column c occupies bits [127-32c -: 32]; column 0 is the most significant word.
    function automatic logic [31:0] col_slice(input logic [127:0] s, input logic [1:0] c);
        logic [31:0] r;
        case (c)
            2'd0:    r = s[127:96];
            2'd1:    r = s[95:64];
            2'd2:    r = s[63:32];
            default: r = s[31:0];
        endcase
        return r;
    endfunction

    function automatic logic [127:0] col_put(input logic [127:0] s, input logic [1:0] c,
                                             input logic [31:0] w);
        logic [127:0] r;
        r = s;
        case (c)
            2'd0:    r[127:96] = w;
            2'd1:    r[95:64]  = w;
            2'd2:    r[63:32]  = w;
            default: r[31:0]   = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mixcol_word.sv
// One AES column through (Inv)MixColumns; the inverse is a cheap pre-pass feeding the forward matrix.
module mixcol_word
    import aes_mix_pkg::*;
#(
    parameter bit INV_EN = 1'b1
) (
    input  logic [31:0] col_in,
    input  logic        inv,
    output logic [31:0] col_out
);

    logic [31:0] pre;
    logic [7:0]  p0, p1, p2, p3;

    if (INV_EN) begin : g_inv
        logic [7:0] u, v;
        assign u   = xtime(xtime(col_in[31:24] ^ col_in[15:8]));
        assign v   = xtime(xtime(col_in[23:16] ^ col_in[7:0]));
        assign pre = inv ? (col_in ^ {u, v, u, v}) : col_in;
    end else begin : g_fwd
        logic unused_inv;
        assign unused_inv = inv;
        assign pre        = col_in;
    end

    assign p0 = pre[31:24];
    assign p1 = pre[23:16];
    assign p2 = pre[15:8];
    assign p3 = pre[7:0];

    assign col_out[31:24] = xtime(p0) ^ xtime(p1) ^ p1 ^ p2 ^ p3;
    assign col_out[23:16] = p0 ^ xtime(p1) ^ xtime(p2) ^ p2 ^ p3;
    assign col_out[15:8]  = p0 ^ p1 ^ xtime(p2) ^ xtime(p3) ^ p3;
    assign col_out[7:0]   = xtime(p0) ^ p0 ^ p1 ^ p2 ^ xtime(p3);

endmodule

// File: rtl/mixcol_engine.sv
// Iterative MixColumns/InvMixColumns over a 128-bit AES state, COLS_PER_CYCLE columns per busy cycle.
//   state | meaning
//   IDLE  | waiting for an input state, in_ready=1
//   BUSY  | transforming columns in place in the working register
//   DONE  | result held on out_data until out_ready
module mixcol_engine
    import aes_mix_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1,
    parameter bit INV_EN         = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("mixcol_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    state_t         state;
    logic [1:0]     col;
    logic [127:0]   work;
    logic           inv_q;
    logic [127:0]   work_next;
    logic           last_beat;
    logic [31:0]    w_in  [COLS_PER_CYCLE];
    logic [31:0]    w_out [COLS_PER_CYCLE];

    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_word
        assign w_in[k] = col_slice(work, col + 2'(k));
        mixcol_word #(.INV_EN(INV_EN)) u_word (
            .col_in  (w_in[k]),
            .inv     (inv_q),
            .col_out (w_out[k])
        );
    end

    always_comb begin
        work_next = work;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            work_next = col_put(work_next, col + 2'(k), w_out[k]);
        end
    end

    // Final beat is the one whose columns reach the end of the state.
    assign last_beat = ((3'(col) + 3'(COLS_PER_CYCLE)) == 3'd4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            col   <= 2'd0;
            work  <= '0;
            inv_q <= 1'b0;
        end else if (clear) begin
            state <= ST_IDLE;
            col   <= 2'd0;
            work  <= '0;
            inv_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        work  <= in_data;
                        inv_q <= in_inv & INV_EN;
                        col   <= 2'd0;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    work <= work_next;
                    col  <= col + 2'(COLS_PER_CYCLE);
                    if (last_beat) state <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign out_data  = work;

endmodule
